// File: rtl/cpu_decode_stage.sv
// cpu_decode_stage
//   Registered instruction-decode stage for the accelerator control CPU.
//   Instructions arrive from fetch over a valid/ready handshake and each legal
//   one produces a single registered control bundle one cycle later. Load-use
//   hazards stall fetch for LOAD_USE_STALL cycles. Illegal opcodes are consumed
//   as bubbles and raise a sticky error flag.
//
//   Instruction layout (MSB first): opcode[OP_W] | rd | rs1 | rs2 | don't-care.
//   Class decode uses the top 8 opcode bits.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   if_valid/if_ready     fetch handshake; if_instr is the instruction word
//   flush                 kill the held instruction and any pending stall
//   ex_ready              execute consumes the id_* bundle this cycle
//   id_valid, id_*        registered control bundle
//   err, err_clr          sticky illegal-opcode flag and its clear (set wins)
//   perf_stall_cycles     (CPU_DECODE_PERF_EN only) saturating hazard-cycle count
//   perf_illegal          (CPU_DECODE_PERF_EN only) saturating illegal-accept count
//
// Build option
//   CPU_DECODE_PERF_EN    when defined, adds the two performance counters.

module cpu_decode_stage #(
   parameter int INSTR_W        = 32,
   parameter int OP_W           = 8,
   parameter int REG_ADDR_W     = 4,
   parameter int LOAD_USE_STALL = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_valid,
   output logic                  if_ready,
   input  logic [INSTR_W-1:0]    if_instr,
   input  logic                  flush,
   input  logic                  ex_ready,
   output logic                  id_valid,
   output logic [OP_W-1:0]       id_alu_op,
   output logic                  id_alu_imm_src,
   output logic                  id_rf_write_en,
   output logic                  id_datamem_write_en,
   output logic                  id_datamem_read_en,
   output logic                  id_rf_write_mem_src,
   output logic                  id_pc_src,
   output logic                  id_pc_jmp_src,
   output logic [REG_ADDR_W-1:0] id_rd,
   output logic [REG_ADDR_W-1:0] id_rs1,
   output logic [REG_ADDR_W-1:0] id_rs2,
   output logic                  err,
   input  logic                  err_clr
`ifdef CPU_DECODE_PERF_EN
   ,
   output logic [15:0]           perf_stall_cycles,
   output logic [15:0]           perf_illegal
`endif
);

   localparam int OP_LSB  = INSTR_W - OP_W;
   localparam int RD_LSB  = OP_LSB - REG_ADDR_W;
   localparam int RS1_LSB = RD_LSB - REG_ADDR_W;
   localparam int RS2_LSB = RS1_LSB - REG_ADDR_W;

   // The counter holds the hazard cycles still owed after the cycle in which
   // the load leaves; the leaving cycle itself is covered by a look-ahead.
   localparam int CNT_W    = (LOAD_USE_STALL < 2) ? 1 : $clog2(LOAD_USE_STALL + 1);
   localparam int RELOAD_I = (LOAD_USE_STALL > 0) ? LOAD_USE_STALL - 1 : 0;
   localparam logic [CNT_W-1:0] STALL_MAX    = CNT_W'(LOAD_USE_STALL);
   localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(RELOAD_I);

   function automatic logic is_alu(input logic [7:0] op);
      return (op[7:4] == 4'h1) || (op[7:4] == 4'h2);
   endfunction

   function automatic logic is_branch(input logic [7:0] op);
      return op[7:4] == 4'h3;
   endfunction

   function automatic logic is_load(input logic [7:0] op);
      return (op == 8'h81) || (op == 8'h85);
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return (op == 8'h83) || (op == 8'h87);
   endfunction

   function automatic logic is_legal(input logic [7:0] op);
      return (op == 8'h00) || is_alu(op) || is_branch(op) || is_load(op) || is_store(op);
   endfunction

   logic [7:0]            op8_s;
   logic                  op_bit0_s;
   logic [REG_ADDR_W-1:0] rd_s;
   logic [REG_ADDR_W-1:0] rs1_s;
   logic [REG_ADDR_W-1:0] rs2_s;
   logic                  legal_s;
   logic                  leave_load_s;
   logic [CNT_W-1:0]      stall_eff_s;
   logic [REG_ADDR_W-1:0] rd_eff_s;
   logic                  match_s;
   logic                  hazard_s;
   logic                  accept_s;

   logic [CNT_W-1:0]      stall_cnt_r;
   logic [REG_ADDR_W-1:0] rd_latched_r;

   assign op8_s     = if_instr[INSTR_W-1 -: 8];
   assign op_bit0_s = if_instr[OP_LSB];
   assign rd_s      = if_instr[RD_LSB  +: REG_ADDR_W];
   assign rs1_s     = if_instr[RS1_LSB +: REG_ADDR_W];
   assign rs2_s     = if_instr[RS2_LSB +: REG_ADDR_W];

   generate
      if (RS2_LSB > 0) begin : g_low_bits
         logic unused_low_bits_s;
         assign unused_low_bits_s = ^if_instr[RS2_LSB-1:0];
      end
   endgenerate

   // Hazard detection and handshake: a load leaving this cycle is compared
   // against directly so its dependant cannot slip in behind it.
   always_comb begin
      leave_load_s = id_valid & ex_ready & id_datamem_read_en;
      legal_s      = is_legal(op8_s);
      if (leave_load_s) begin
         stall_eff_s = STALL_MAX;
         rd_eff_s    = id_rd;
      end else begin
         stall_eff_s = stall_cnt_r;
         rd_eff_s    = rd_latched_r;
      end
      match_s  = ((rs1_s == rd_eff_s) &&
                  (is_alu(op8_s) || is_load(op8_s) || is_store(op8_s) || is_branch(op8_s))) ||
                 ((rs2_s == rd_eff_s) && (!op_bit0_s || is_store(op8_s)));
      hazard_s = (stall_eff_s != '0) & if_valid & match_s;
      if_ready = ~flush & ~hazard_s & (~id_valid | ex_ready);
      accept_s = if_valid & if_ready;
   end

   // Control bundle register: load on legal accept, drop on consume or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid            <= 1'b0;
         id_alu_op           <= '0;
         id_alu_imm_src      <= 1'b0;
         id_rf_write_en      <= 1'b0;
         id_datamem_write_en <= 1'b0;
         id_datamem_read_en  <= 1'b0;
         id_rf_write_mem_src <= 1'b0;
         id_pc_src           <= 1'b0;
         id_pc_jmp_src       <= 1'b0;
         id_rd               <= '0;
         id_rs1              <= '0;
         id_rs2              <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (accept_s && legal_s) begin
         id_valid            <= 1'b1;
         id_alu_op           <= if_instr[INSTR_W-1 -: OP_W];
         id_alu_imm_src      <= op_bit0_s;
         id_rf_write_en      <= is_alu(op8_s) | is_load(op8_s);
         id_datamem_write_en <= is_store(op8_s);
         id_datamem_read_en  <= is_load(op8_s);
         id_rf_write_mem_src <= is_load(op8_s);
         id_pc_src           <= is_branch(op8_s);
         id_pc_jmp_src       <= (op8_s == 8'h3F);
         id_rd               <= rd_s;
         id_rs1              <= rs1_s;
         id_rs2              <= rs2_s;
      end else if (accept_s) begin
         // Illegal opcode: consumed but issued as a bubble.
         id_valid <= 1'b0;
      end else if (ex_ready) begin
         id_valid <= 1'b0;
      end else begin
         id_valid <= id_valid;
      end
   end

   // Load-use stall counter and latched load destination.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r  <= '0;
         rd_latched_r <= '0;
      end else if (flush) begin
         stall_cnt_r  <= '0;
      end else if (leave_load_s) begin
         stall_cnt_r  <= STALL_RELOAD;
         rd_latched_r <= id_rd;
      end else if (stall_cnt_r != '0) begin
         stall_cnt_r  <= stall_cnt_r - CNT_W'(1);
      end else begin
         stall_cnt_r  <= stall_cnt_r;
      end
   end

   // Sticky illegal-opcode flag; a new illegal accept beats err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (accept_s && !legal_s) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end else begin
         err <= err;
      end
   end

`ifdef CPU_DECODE_PERF_EN
   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cycles <= 16'h0000;
         perf_illegal      <= 16'h0000;
      end else begin
         if (hazard_s && (perf_stall_cycles != 16'hFFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 16'h0001;
         end else begin
            perf_stall_cycles <= perf_stall_cycles;
         end
         if (accept_s && !legal_s && (perf_illegal != 16'hFFFF)) begin
            perf_illegal <= perf_illegal + 16'h0001;
         end else begin
            perf_illegal <= perf_illegal;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cpu_decode_stage.sv
// tb_cpu_decode_stage
//   Two decode stages share one stimulus stream: index 0 uses LOAD_USE_STALL=1,
//   index 1 uses LOAD_USE_STALL=0. A cycle-level reference model derived from
//   the instruction-class rules predicts handshake, bundle and error state for
//   each instance. Directed scenarios come first, then randomized traffic, then
//   an asynchronous reset in the middle of a stall.

module tb_cpu_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        flush;
   logic        ex_ready;
   logic        err_clr;

   logic        o_valid [2];
   logic        o_ready [2];
   logic [7:0]  o_op    [2];
   logic        o_imm   [2];
   logic        o_rfw   [2];
   logic        o_dmw   [2];
   logic        o_dmr   [2];
   logic        o_msrc  [2];
   logic        o_pcs   [2];
   logic        o_jmp   [2];
   logic [3:0]  o_rd    [2];
   logic [3:0]  o_rs1   [2];
   logic [3:0]  o_rs2   [2];
   logic        o_err   [2];
`ifdef CPU_DECODE_PERF_EN
   logic [15:0] o_pst   [2];
   logic [15:0] o_pil   [2];
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   logic        m_valid [2];
   logic [31:0] m_instr [2];
   logic        m_err   [2];
   int          m_last  [2];
   logic [3:0]  m_rdl   [2];
   logic [15:0] m_pst   [2];
   logic [15:0] m_pil   [2];
   logic        e_rdy   [2];
   logic        e_haz   [2];
   logic        e_leave [2];
   logic        obs_ready [2];

   always #5 clk = ~clk;

   cpu_decode_stage #(.LOAD_USE_STALL(1)) dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(o_ready[0]),
      .if_instr(if_instr), .flush(flush), .ex_ready(ex_ready), .id_valid(o_valid[0]),
      .id_alu_op(o_op[0]), .id_alu_imm_src(o_imm[0]), .id_rf_write_en(o_rfw[0]),
      .id_datamem_write_en(o_dmw[0]), .id_datamem_read_en(o_dmr[0]),
      .id_rf_write_mem_src(o_msrc[0]), .id_pc_src(o_pcs[0]), .id_pc_jmp_src(o_jmp[0]),
      .id_rd(o_rd[0]), .id_rs1(o_rs1[0]), .id_rs2(o_rs2[0]), .err(o_err[0]),
      .err_clr(err_clr)
`ifdef CPU_DECODE_PERF_EN
      , .perf_stall_cycles(o_pst[0]), .perf_illegal(o_pil[0])
`endif
   );

   cpu_decode_stage #(.LOAD_USE_STALL(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(o_ready[1]),
      .if_instr(if_instr), .flush(flush), .ex_ready(ex_ready), .id_valid(o_valid[1]),
      .id_alu_op(o_op[1]), .id_alu_imm_src(o_imm[1]), .id_rf_write_en(o_rfw[1]),
      .id_datamem_write_en(o_dmw[1]), .id_datamem_read_en(o_dmr[1]),
      .id_rf_write_mem_src(o_msrc[1]), .id_pc_src(o_pcs[1]), .id_pc_jmp_src(o_jmp[1]),
      .id_rd(o_rd[1]), .id_rs1(o_rs1[1]), .id_rs2(o_rs2[1]), .err(o_err[1]),
      .err_clr(err_clr)
`ifdef CPU_DECODE_PERF_EN
      , .perf_stall_cycles(o_pst[1]), .perf_illegal(o_pil[1])
`endif
   );

   function automatic logic op_load(input logic [7:0] op);
      return op inside {8'h81, 8'h85};
   endfunction

   function automatic logic op_store(input logic [7:0] op);
      return op inside {8'h83, 8'h87};
   endfunction

   function automatic logic op_legal(input logic [7:0] op);
      return (op == 8'h00) || (op[7:4] inside {4'h1, 4'h2, 4'h3}) ||
             (op inside {8'h81, 8'h83, 8'h85, 8'h87});
   endfunction

   // Does the instruction read register r?
   function automatic logic reads_reg(input logic [31:0] ins, input logic [3:0] r);
      logic [7:0] op;
      logic       cls;
      op  = ins[31:24];
      cls = (op[7:4] inside {4'h1, 4'h2, 4'h3}) || op_load(op) || op_store(op);
      return ((ins[19:16] == r) && cls) || ((ins[15:12] == r) && (!op[0] || op_store(op)));
   endfunction

   // Expected bundle: {alu_op, imm, rf_we, dm_we, dm_re, mem_src, pc_src, jmp, rd, rs1, rs2}
   function automatic logic [26:0] exp_pack(input logic [31:0] ins);
      logic [7:0] op;
      logic       alu;
      logic       br;
      logic       ld;
      logic       st;
      op  = ins[31:24];
      alu = op[7:4] inside {4'h1, 4'h2};
      br  = op[7:4] == 4'h3;
      ld  = op_load(op);
      st  = op_store(op);
      return {op, op[0], alu | ld, st, ld, ld, br, op == 8'h3F,
              ins[23:20], ins[19:16], ins[15:12]};
   endfunction

   function automatic logic [26:0] dut_pack(input int k);
      return {o_op[k], o_imm[k], o_rfw[k], o_dmw[k], o_dmr[k], o_msrc[k], o_pcs[k],
              o_jmp[k], o_rd[k], o_rs1[k], o_rs2[k]};
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0;
         m_instr[k] = 32'h0;
         m_err[k]   = 1'b0;
         m_last[k]  = -1000;
         m_rdl[k]   = 4'h0;
         m_pst[k]   = 16'h0;
         m_pil[k]   = 16'h0;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_valid"}, k, 32'(o_valid[k]), 32'h0);
         chk({tag, "_err"}, k, 32'(o_err[k]), 32'h0);
         chk({tag, "_bundle"}, k, 32'(dut_pack(k)), 32'h0);
`ifdef CPU_DECODE_PERF_EN
         chk({tag, "_perf_stall"}, k, 32'(o_pst[k]), 32'h0);
         chk({tag, "_perf_illegal"}, k, 32'(o_pil[k]), 32'h0);
`endif
      end
   endtask

   // One clock cycle: drive, check at negedge, advance the model at posedge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic fl,
                        input logic exr, input logic ec);
      int         n;
      logic       win;
      logic       acc;
      logic [3:0] rdc;
      if_valid = v;
      if_instr = ins;
      flush    = fl;
      ex_ready = exr;
      err_clr  = ec;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n          = (k == 0) ? 1 : 0;
         e_leave[k] = m_valid[k] && exr && op_load(m_instr[k][31:24]);
         win        = (n > 0) && (e_leave[k] || (cyc - m_last[k] < n));
         rdc        = e_leave[k] ? m_instr[k][23:20] : m_rdl[k];
         e_haz[k]   = win && v && reads_reg(ins, rdc);
         e_rdy[k]   = !fl && !e_haz[k] && (!m_valid[k] || exr);
         obs_ready[k] = o_ready[k];
         chk("if_ready", k, 32'(o_ready[k]), 32'(e_rdy[k]));
         chk("id_valid", k, 32'(o_valid[k]), 32'(m_valid[k]));
         chk("err", k, 32'(o_err[k]), 32'(m_err[k]));
         if (m_valid[k]) chk("bundle", k, 32'(dut_pack(k)), 32'(exp_pack(m_instr[k])));
`ifdef CPU_DECODE_PERF_EN
         chk("perf_stall", k, 32'(o_pst[k]), 32'(m_pst[k]));
         chk("perf_illegal", k, 32'(o_pil[k]), 32'(m_pil[k]));
`endif
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         acc = v && e_rdy[k];
         if (e_haz[k] && m_pst[k] != 16'hFFFF) m_pst[k]++;
         if (acc && !op_legal(ins[31:24]) && m_pil[k] != 16'hFFFF) m_pil[k]++;
         if (acc && !op_legal(ins[31:24])) m_err[k] = 1'b1;
         else if (ec) m_err[k] = 1'b0;
         if (fl) begin
            m_valid[k] = 1'b0;
            m_last[k]  = -1000;
         end else begin
            if (e_leave[k]) begin
               m_last[k] = cyc;
               m_rdl[k]  = m_instr[k][23:20];
            end
            if (acc && op_legal(ins[31:24])) begin
               m_valid[k] = 1'b1;
               m_instr[k] = ins;
            end else if (acc || exr) begin
               m_valid[k] = 1'b0;
            end
         end
      end
      cyc++;
      #1;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [7:0] op;
      case ($urandom_range(0, 9))
         0:       op = 8'h00;
         1, 2:    op = 8'h10 + 8'($urandom_range(0, 31));
         3:       op = 8'h30 + 8'($urandom_range(0, 15));
         4, 5:    op = ($urandom_range(0, 1) != 0) ? 8'h81 : 8'h85;
         6:       op = ($urandom_range(0, 1) != 0) ? 8'h83 : 8'h87;
         7: begin
            case ($urandom_range(0, 3))
               0:       op = 8'hFF;
               1:       op = 8'h40;
               2:       op = 8'h82;
               default: op = 8'h01;
            endcase
         end
         default: op = 8'($urandom);
      endcase
      return {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 12'($urandom)};
   endfunction

   initial begin
      rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'h0;
      flush = 1'b0; ex_ready = 1'b1; err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_n = 1'b1;

      // back-to-back ALU stream at full throughput
      cycle(1'b1, 32'h10123000, 1'b0, 1'b1, 1'b0);
      chk("stream0_valid", 0, 32'(o_valid[0]), 32'h1);
      chk("stream0_rfw", 0, 32'(o_rfw[0]), 32'h1);
      chk("stream0_imm", 0, 32'(o_imm[0]), 32'h0);
      cycle(1'b1, 32'h214000AB, 1'b0, 1'b1, 1'b0);
      chk("stream1_valid", 0, 32'(o_valid[0]), 32'h1);
      chk("stream1_imm", 0, 32'(o_imm[0]), 32'h1);
      chk("stream1_rd", 0, 32'(o_rd[0]), 32'h4);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

      // load-use: one bubble with stall 1, none with stall 0
      cycle(1'b1, 32'h81500000, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h10650000, 1'b0, 1'b1, 1'b0);
      chk("lu_ready_stall", 0, 32'(obs_ready[0]), 32'h0);
      chk("lu_ready_nostall", 1, 32'(obs_ready[1]), 32'h1);
      chk("lu_bubble", 0, 32'(o_valid[0]), 32'h0);
      chk("lu_nobubble", 1, 32'(o_valid[1]), 32'h1);
      cycle(1'b1, 32'h10650000, 1'b0, 1'b1, 1'b0);
      chk("lu_issue_valid", 0, 32'(o_valid[0]), 32'h1);
      chk("lu_issue_op", 0, 32'(o_op[0]), 32'h10);

      // illegal opcode and sticky error
      cycle(1'b1, 32'hFF000000, 1'b0, 1'b1, 1'b0);
      chk("ill_err", 0, 32'(o_err[0]), 32'h1);
      chk("ill_valid", 0, 32'(o_valid[0]), 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("ill_clr", 0, 32'(o_err[0]), 32'h0);
      cycle(1'b1, 32'hFF000000, 1'b0, 1'b1, 1'b1);
      chk("ill_set_wins", 0, 32'(o_err[0]), 32'h1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

      // execute back-pressure holds the bundle
      cycle(1'b1, 32'h214000AB, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'h10123000, 1'b0, 1'b0, 1'b0);
         chk("hold_ready", 0, 32'(obs_ready[0]), 32'h0);
         chk("hold_op", 0, 32'(o_op[0]), 32'h21);
      end
      cycle(1'b1, 32'h10123000, 1'b0, 1'b1, 1'b0);
      chk("release_op", 0, 32'(o_op[0]), 32'h10);

      // flush during a load-use stall with JMPI waiting
      cycle(1'b1, 32'h81000000, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h3F000010, 1'b1, 1'b1, 1'b0);
      chk("flush_valid", 0, 32'(o_valid[0]), 32'h0);
      cycle(1'b1, 32'h3F000010, 1'b0, 1'b1, 1'b0);
      chk("flush_ready_next", 0, 32'(obs_ready[0]), 32'h1);
      chk("jmpi_jmp", 0, 32'(o_jmp[0]), 32'h1);
      chk("jmpi_pc", 0, 32'(o_pcs[0]), 32'h1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 4) != 0, rnd_instr(), $urandom_range(0, 19) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      end

      // asynchronous reset in the middle of a load-use stall
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'hFF000000, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h81300000, 1'b0, 1'b1, 1'b0);
      if_valid = 1'b1; if_instr = 32'h10730000; flush = 1'b0;
      ex_ready = 1'b1; err_clr = 1'b0;
      @(negedge clk);
      chk("pre_rst_stall", 0, 32'(o_ready[0]), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("midrst");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 32'h10730000, 1'b0, 1'b1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
